// File: rtl/pixel_readout_capture_if.sv
// Pixel stream link between the readout capture block and its downstream consumer.
// A transfer happens on a rising edge where valid and ready are both high.
interface pixel_readout_capture_if #(
  parameter int DATA_W = 8,
  parameter int COL_W  = 1
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              row;
  logic [COL_W-1:0]  col;
  logic              last;

  modport master (output valid, data, row, col, last, input ready);
  modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/pixel_readout_capture.sv
// Captures the two ADC rows sequenced by the pixel camera controller and streams each
// completed frame pixel by pixel, flagging sequencing violations and dropped frames.
module pixel_readout_capture #(
  parameter int DATA_W = 8,
  parameter int NCOL   = 2,
  localparam int COL_W = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     expose,
  input  logic                     erase,
  input  logic                     nre_1,
  input  logic                     nre_2,
  input  logic                     adc,
  input  logic [NCOL*DATA_W-1:0]   adc_data,
  input  logic                     clear_flags,
  pixel_readout_capture_if.master  pix,
  output logic [7:0]               frame_count,
  output logic                     proto_err,
  output logic                     overrun,
  output logic                     busy
);

  typedef enum logic [2:0] {
    C_IDLE,
    C_EXPOSE,
    C_ROW1,
    C_GAP,
    C_ROW2
  } cap_state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOL - 1);

  cap_state_t             state_reg, state_next;
  logic                   row1_got_reg, row1_got_next;
  logic                   row2_got_reg, row2_got_next;
  logic [NCOL*DATA_W-1:0] cap0_reg, cap1_reg;
  logic [NCOL*DATA_W-1:0] obuf0_reg, obuf1_reg;
  logic                   out_valid_reg;
  logic                   row_reg;
  logic [COL_W-1:0]       col_reg;
  logic [7:0]             frame_count_reg;
  logic                   proto_err_reg, overrun_reg, busy_reg;

  logic cap0_we, cap1_we, publish, seq_err;
  logic xfer, last_px, last_xfer, pub_ok, drop;

  // Sequencing FSM: NRE_x low selects a row, so ADC with both low is always illegal.
  always_comb begin
    state_next    = state_reg;
    row1_got_next = row1_got_reg;
    row2_got_next = row2_got_reg;
    cap0_we       = 1'b0;
    cap1_we       = 1'b0;
    publish       = 1'b0;
    seq_err       = adc && !nre_1 && !nre_2;
    case (state_reg)
      C_IDLE: begin
        row1_got_next = 1'b0;
        row2_got_next = 1'b0;
        if (adc)    seq_err    = 1'b1;
        if (expose) state_next = C_EXPOSE;
      end
      C_EXPOSE: begin
        if (adc) seq_err = 1'b1;
        if (erase)       state_next = C_IDLE;
        else if (!nre_1) state_next = C_ROW1;
      end
      C_ROW1: begin
        if (adc) begin
          if (row1_got_reg) begin
            seq_err = 1'b1;
          end else begin
            cap0_we       = 1'b1;
            row1_got_next = 1'b1;
          end
        end
        if (erase) begin
          state_next = C_IDLE;
        end else if (nre_1) begin
          if (row1_got_reg) begin
            state_next = C_GAP;
          end else begin
            seq_err    = 1'b1;
            state_next = C_IDLE;
          end
        end
      end
      C_GAP: begin
        if (adc) seq_err = 1'b1;
        if (erase)       state_next = C_IDLE;
        else if (!nre_2) state_next = C_ROW2;
      end
      C_ROW2: begin
        if (adc) begin
          if (row2_got_reg) begin
            seq_err = 1'b1;
          end else begin
            cap1_we       = 1'b1;
            row2_got_next = 1'b1;
          end
        end
        // The controller raises NRE_2 and Erase together, so end-of-row wins here.
        if (nre_2) begin
          if (row2_got_reg) publish = 1'b1;
          else              seq_err = 1'b1;
          state_next = C_IDLE;
        end else if (erase) begin
          state_next = C_IDLE;
        end
      end
      default: state_next = C_IDLE;
    endcase
  end

  assign xfer      = out_valid_reg && pix.ready;
  assign last_px   = row_reg && (col_reg == LAST_COL);
  assign last_xfer = xfer && last_px;
  assign pub_ok    = publish && (!out_valid_reg || last_xfer);
  assign drop      = publish && !pub_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= C_IDLE;
      row1_got_reg    <= 1'b0;
      row2_got_reg    <= 1'b0;
      cap0_reg        <= '0;
      cap1_reg        <= '0;
      obuf0_reg       <= '0;
      obuf1_reg       <= '0;
      out_valid_reg   <= 1'b0;
      row_reg         <= 1'b0;
      col_reg         <= '0;
      frame_count_reg <= 8'd0;
      proto_err_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row1_got_reg <= row1_got_next;
      row2_got_reg <= row2_got_next;
      busy_reg     <= (state_next != C_IDLE);
      if (cap0_we) cap0_reg <= adc_data;
      if (cap1_we) cap1_reg <= adc_data;

      // A publish on the last-transfer edge keeps valid high with the new frame's first pixel.
      if (pub_ok) begin
        obuf0_reg       <= cap0_reg;
        obuf1_reg       <= cap1_reg;
        out_valid_reg   <= 1'b1;
        row_reg         <= 1'b0;
        col_reg         <= '0;
        frame_count_reg <= frame_count_reg + 8'd1;
      end else if (xfer) begin
        if (last_px) begin
          out_valid_reg <= 1'b0;
          row_reg       <= 1'b0;
          col_reg       <= '0;
        end else if (col_reg == LAST_COL) begin
          row_reg <= 1'b1;
          col_reg <= '0;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end

      if (seq_err)          proto_err_reg <= 1'b1;
      else if (clear_flags) proto_err_reg <= 1'b0;
      if (drop)             overrun_reg   <= 1'b1;
      else if (clear_flags) overrun_reg   <= 1'b0;
    end
  end

  logic [DATA_W-1:0] col_pix [NCOL];

  genvar gi;
  generate
    for (gi = 0; gi < NCOL; gi++) begin : g_col_mux
      assign col_pix[gi] = row_reg ? obuf1_reg[gi*DATA_W +: DATA_W]
                                   : obuf0_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign pix.valid   = out_valid_reg;
  assign pix.data    = col_pix[col_reg];
  assign pix.row     = row_reg;
  assign pix.col     = col_reg;
  assign pix.last    = out_valid_reg && last_px;
  assign frame_count = frame_count_reg;
  assign proto_err   = proto_err_reg;
  assign overrun     = overrun_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Scoreboard bench for pixel_readout_capture: expected pixels are queued as frames are
// driven and compared as the stream hands them over.
module tb_pixel_readout_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        expose = 1'b0, erase = 1'b0, nre_1 = 1'b1, nre_2 = 1'b1, adc = 1'b0;
  logic [15:0] adc_data = 16'h0;
  logic        clear_flags = 1'b0;
  logic [7:0]  frame_count;
  logic        proto_err, overrun, busy;

  pixel_readout_capture_if #(.DATA_W(8), .COL_W(1)) pix ();

  pixel_readout_capture #(.DATA_W(8), .NCOL(2)) dut (
    .clk(clk), .rst(rst), .expose(expose), .erase(erase), .nre_1(nre_1), .nre_2(nre_2),
    .adc(adc), .adc_data(adc_data), .clear_flags(clear_flags), .pix(pix),
    .frame_count(frame_count), .proto_err(proto_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_fc = 0;
  int xfers = 0;
  int cyc_n = 0;
  int first_cyc = 0, last_cyc = 0;
  int rdy_mode = 0, rdy_cnt = 0, rdy_start = 0;
  logic held = 1'b0;
  int held_val = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pk(input logic last, input logic row, input logic col, input logic [7:0] d);
    return int'({last, row, col, d});
  endfunction

  function automatic int cur_pix();
    return pk(pix.last, pix.row, pix.col, pix.data);
  endfunction

  task automatic push_frame(input logic [15:0] d1, input logic [15:0] d2);
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, d1[7:0]));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b1, d1[15:8]));
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, d2[7:0]));
    exp_q.push_back(pk(1'b1, 1'b1, 1'b1, d2[15:8]));
  endtask

  // Sink side: compare every transfer, and verify stalled outputs hold.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", int'(pix.valid), 1);
        check("hold_pixel", cur_pix(), held_val);
      end
      if (pix.valid && pix.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", cur_pix(), -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("pixel", cur_pix(), e);
          if (!pix.row && pix.col == 1'b0) first_cyc = cyc_n;
          if (pix.last) last_cyc = cyc_n;
        end
        xfers++;
      end
      held = pix.valid && !pix.ready;
      held_val = cur_pix();
    end
  end

  task automatic cyc(input logic ex, input logic er, input logic n1, input logic n2,
                     input logic a, input logic [15:0] d, input logic clr = 1'b0);
    expose = ex; erase = er; nre_1 = n1; nre_2 = n2; adc = a; adc_data = d; clear_flags = clr;
    case (rdy_mode)
      0:       pix.ready = 1'b1;
      1:       pix.ready = 1'b0;
      2:       pix.ready = (rdy_cnt % 3 == 0);
      default: pix.ready = (rdy_cnt >= rdy_start);
    endcase
    rdy_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic clr = 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, clr);
  endtask

  task automatic set_ready(input int mode, input int start = 0);
    rdy_mode = mode; rdy_cnt = 0; rdy_start = start;
  endtask

  // Full controller sequence; NRE_2 and Erase rise together at the end of row 2.
  task automatic frame(input logic [15:0] d1, input logic [15:0] d2, input logic dbl_adc = 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, d1);
    if (dbl_adc) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDEAD);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, d2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic drain();
    int n = 0;
    set_ready(0);
    while ((exp_q.size() != 0 || pix.valid) && n < 60) begin
      idle();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    idle();
  endtask

  initial begin
    pix.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", int'(pix.valid), 0);
    check("rst_pixel", cur_pix(), 0);
    check("rst_fc", int'(frame_count), 0);
    check("rst_flags", int'({proto_err, overrun, busy}), 0);

    // Nominal frame with ready held high
    set_ready(0);
    frame(16'h1122, 16'h3344); push_frame(16'h1122, 16'h3344); exp_fc++;
    check("nom_valid", int'(pix.valid), 1);
    drain();
    check("nom_spacing", last_cyc - first_cyc, 3);
    check("nom_fc", int'(frame_count), exp_fc);
    check("nom_flags", int'({proto_err, overrun}), 0);

    // Backpressure 1,0,0,...
    begin
      int x0;
      x0 = xfers;
      set_ready(2);
      frame(16'hA1B2, 16'hC3D4); push_frame(16'hA1B2, 16'hC3D4); exp_fc++;
      for (int i = 0; i < 14; i++) idle();
      check("bp_xfers", xfers - x0, 4);
      drain();
      check("bp_overrun", int'(overrun), 0);
      check("bp_fc", int'(frame_count), exp_fc);
    end

    // Overrun: second frame lands while the first is unread
    set_ready(1);
    frame(16'h5566, 16'h7788); push_frame(16'h5566, 16'h7788); exp_fc++;
    frame(16'h99AA, 16'hBBCC);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_fc", int'(frame_count), exp_fc);
    drain();
    idle(1'b1);
    check("ovr_clear", int'(overrun), 0);

    // Publish on the same edge as the previous frame's last transfer
    set_ready(1);
    frame(16'h0A0B, 16'h0C0D); push_frame(16'h0A0B, 16'h0C0D); exp_fc++;
    set_ready(3, 3);
    frame(16'h1A1B, 16'h1C1D); push_frame(16'h1A1B, 16'h1C1D); exp_fc++;
    check("coin_overrun", int'(overrun), 0);
    check("coin_valid", int'(pix.valid), 1);
    check("coin_pixel", cur_pix(), pk(1'b0, 1'b0, 1'b0, 8'h1B));
    check("coin_fc", int'(frame_count), exp_fc);
    drain();

    // Abort with Erase during the inter-row gap
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7777);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("gap_busy", int'(busy), 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("abort_busy", int'(busy), 0);
    idle(); idle();
    check("abort_valid", int'(pix.valid), 0);
    check("abort_fc", int'(frame_count), exp_fc);
    check("abort_flags", int'({proto_err, overrun}), 0);

    // ADC pulse while exposing
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    check("exp_adc_err", int'(proto_err), 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    idle(1'b1);
    check("clear_err", int'(proto_err), 0);

    // Row 1 ends without an ADC sample
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("norow_err", int'(proto_err), 1);
    check("norow_busy", int'(busy), 0);
    idle(1'b1);

    // Repeat ADC in row 1: first sample kept, frame still published
    frame(16'h4455, 16'h6677, 1'b1); push_frame(16'h4455, 16'h6677); exp_fc++;
    check("dbl_err", int'(proto_err), 1);
    drain();
    check("dbl_fc", int'(frame_count), exp_fc);
    idle(1'b1);

    // Asynchronous reset while a stalled pixel is presented
    set_ready(1);
    frame(16'h0102, 16'h0304); push_frame(16'h0102, 16'h0304);
    check("pre_rst_valid", int'(pix.valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(pix.valid), 0);
    check("arst_pixel", cur_pix(), 0);
    check("arst_fc", int'(frame_count), 0);
    check("arst_flags", int'({proto_err, overrun, busy}), 0);
    exp_q.delete();
    exp_fc = 0;
    #3 rst = 1'b0;
    idle();
    set_ready(0);
    frame(16'h1122, 16'h3344); push_frame(16'h1122, 16'h3344); exp_fc++;
    drain();
    check("post_rst_fc", int'(frame_count), exp_fc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
